// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// master: fetch side (req/addr out, ready/rdata in); slave: memory side.
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues imem requests, drives IF/ID.
// Ports: clk, rst_n, PC_sel/branch_target/stall in, imem bus (master),
// ID_instr/ID_pc_plus4/ID_valid out. Macro BRANCH_DELAY_SLOT_EN keeps
// the post-branch slot instead of squashing it.
module fetch_pc_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PC_sel,
    input  logic [ADDR_W-1:0]     branch_target,
    input  logic                  stall,
    fetch_pc_unit_if.master       imem,
    output logic [31:0]           ID_instr,
    output logic [ADDR_W-1:0]     ID_pc_plus4,
    output logic                  ID_valid
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] HELD      = 3'd2;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic [2:0] SLOT_WAIT = 3'd4;
`else
    localparam logic [2:0] DISCARD   = 3'd3;
`endif

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_tgt;
    logic [31:0]       hold_buf;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] tgt;

    assign pc_plus4 = pc + ADDR_W'(4);
    assign tgt      = branch_target & ~ADDR_W'(3);

    // A request is outstanding in every state that waits on memory.
    assign imem.imem_addr = pc;
`ifdef BRANCH_DELAY_SLOT_EN
    assign imem.imem_req  = (state == FETCH) || (state == SLOT_WAIT);
`else
    assign imem.imem_req  = (state == FETCH) || (state == DISCARD);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= PC_INIT;
            pend_tgt    <= '0;
            hold_buf    <= '0;
            ID_instr    <= NOP_INSTR;
            ID_pc_plus4 <= '0;
            ID_valid    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (stall) begin
                        // Word arrived while decode is frozen: park it.
                        if (imem.imem_ready) begin
                            hold_buf <= imem.imem_rdata;
                            state    <= HELD;
                        end
                    end else if (PC_sel) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        if (imem.imem_ready) begin
                            ID_instr    <= imem.imem_rdata;
                            ID_pc_plus4 <= pc_plus4;
                            ID_valid    <= 1'b1;
                            pc          <= tgt;
                        end else begin
                            ID_instr <= NOP_INSTR;
                            ID_valid <= 1'b0;
                            pend_tgt <= tgt;
                            state    <= SLOT_WAIT;
                        end
`else
                        ID_instr <= NOP_INSTR;
                        ID_valid <= 1'b0;
                        if (imem.imem_ready) begin
                            pc <= tgt;
                        end else begin
                            pend_tgt <= tgt;
                            state    <= DISCARD;
                        end
`endif
                    end else if (imem.imem_ready) begin
                        ID_instr    <= imem.imem_rdata;
                        ID_pc_plus4 <= pc_plus4;
                        ID_valid    <= 1'b1;
                        pc          <= pc_plus4;
                    end else begin
                        ID_instr <= NOP_INSTR;
                        ID_valid <= 1'b0;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        state <= FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
                        ID_instr    <= hold_buf;
                        ID_pc_plus4 <= pc_plus4;
                        ID_valid    <= 1'b1;
                        pc          <= PC_sel ? tgt : pc_plus4;
`else
                        if (PC_sel) begin
                            ID_instr <= NOP_INSTR;
                            ID_valid <= 1'b0;
                            pc       <= tgt;
                        end else begin
                            ID_instr    <= hold_buf;
                            ID_pc_plus4 <= pc_plus4;
                            ID_valid    <= 1'b1;
                            pc          <= pc_plus4;
                        end
`endif
                    end
                end
`ifdef BRANCH_DELAY_SLOT_EN
                SLOT_WAIT: begin
                    if (!stall) begin
                        if (imem.imem_ready) begin
                            ID_instr    <= imem.imem_rdata;
                            ID_pc_plus4 <= pc_plus4;
                            ID_valid    <= 1'b1;
                            pc          <= pend_tgt;
                            state       <= FETCH;
                        end else begin
                            ID_instr <= NOP_INSTR;
                            ID_valid <= 1'b0;
                        end
                    end
                end
`else
                DISCARD: begin
                    // Old request still in flight; its data is dropped.
                    if (!stall) begin
                        ID_instr <= NOP_INSTR;
                        ID_valid <= 1'b0;
                        if (imem.imem_ready) begin
                            pc    <= pend_tgt;
                            state <= FETCH;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus
// randomized traffic against a flag-based reference model.
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PC_sel = 1'b0;
    logic [31:0] branch_target = '0;
    logic        stall = 1'b0;
    logic [31:0] ID_instr;
    logic [31:0] ID_pc_plus4;
    logic        ID_valid;

    int n_pass = 0;
    int n_total = 0;

    fetch_pc_unit_if #(.ADDR_W(32)) imem_bus ();

    fetch_pc_unit #(
        .ADDR_W(32),
        .RESET_PC(32'h0),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PC_sel(PC_sel),
        .branch_target(branch_target),
        .stall(stall),
        .imem(imem_bus.master),
        .ID_instr(ID_instr),
        .ID_pc_plus4(ID_pc_plus4),
        .ID_valid(ID_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic sel,
                         input logic [31:0] t, input logic [31:0] d);
        imem_bus.imem_ready = r;
        imem_bus.imem_rdata = d;
        stall = s;
        PC_sel = sel;
        branch_target = t;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        n_total++;
        if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0)
            $display("FAIL rst_bus got req=%0b addr=%h want 0/0",
                     imem_bus.imem_req, imem_bus.imem_addr);
        else n_pass++;
        n_total++;
        if (ID_valid !== 1'b0 || ID_instr !== NOP || ID_pc_plus4 !== 0)
            $display("FAIL rst_id got v=%0b i=%h p=%h want 0/NOP/0",
                     ID_valid, ID_instr, ID_pc_plus4);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0)
            $display("FAIL rst_first got req=%0b addr=%h want 1/0",
                     imem_bus.imem_req, imem_bus.imem_addr);
        else n_pass++;
    endtask

    // Advances n zero-wait fetches from address a, checking each.
    task automatic test_zero_wait(input logic [31:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] ad;
            ad = a + 32'(4 * k);
            n_total++;
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== ad)
                $display("FAIL zw_addr got req=%0b addr=%h want 1/%h",
                         imem_bus.imem_req, imem_bus.imem_addr, ad);
            else n_pass++;
            drive(1, 0, 0, 0, mem_word(ad));
            tick();
            n_total++;
            if (ID_valid !== 1'b1 || ID_instr !== mem_word(ad) ||
                ID_pc_plus4 !== ad + 4)
                $display("FAIL zw_id got v=%0b i=%h p=%h want 1/%h/%h",
                         ID_valid, ID_instr, ID_pc_plus4, mem_word(ad), ad + 4);
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 32'hDEAD_BEEF);
            n_total++;
            if (imem_bus.imem_addr !== 32'h10 || imem_bus.imem_req !== 1'b1)
                $display("FAIL ws_addr got req=%0b addr=%h want 1/10",
                         imem_bus.imem_req, imem_bus.imem_addr);
            else n_pass++;
            tick();
            n_total++;
            if (ID_valid !== 1'b0 || ID_instr !== NOP)
                $display("FAIL ws_bubble got v=%0b i=%h want 0/NOP",
                         ID_valid, ID_instr);
            else n_pass++;
        end
        drive(1, 0, 0, 0, mem_word(32'h10));
        tick();
        n_total++;
        if (ID_valid !== 1'b1 || ID_instr !== mem_word(32'h10) ||
            ID_pc_plus4 !== 32'h14)
            $display("FAIL ws_land got v=%0b i=%h p=%h want 1/%h/14",
                     ID_valid, ID_instr, ID_pc_plus4, mem_word(32'h10));
        else n_pass++;
    endtask

    task automatic test_stall();
        drive(1, 1, 0, 0, mem_word(32'h20));
        tick();
        drive(0, 1, 0, 0, 32'h0BAD_0BAD);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (imem_bus.imem_req !== 1'b0 || ID_valid !== 1'b1 ||
                ID_instr !== mem_word(32'h1c) || ID_pc_plus4 !== 32'h20)
                $display("FAIL st_hold got req=%0b v=%0b i=%h p=%h want 0/1/%h/20",
                         imem_bus.imem_req, ID_valid, ID_instr, ID_pc_plus4,
                         mem_word(32'h1c));
            else n_pass++;
            if (k == 0) tick();
        end
        drive(0, 0, 0, 0, 32'h0BAD_0BAD);
        tick();
        n_total++;
        if (ID_valid !== 1'b1 || ID_instr !== mem_word(32'h20) ||
            ID_pc_plus4 !== 32'h24)
            $display("FAIL st_release got v=%0b i=%h p=%h want 1/%h/24",
                     ID_valid, ID_instr, ID_pc_plus4, mem_word(32'h20));
        else n_pass++;
        n_total++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h24)
            $display("FAIL st_next got req=%0b addr=%h want 1/24",
                     imem_bus.imem_req, imem_bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_stall_masks_branch();
        drive(0, 1, 1, 32'h300, 0);
        tick();
        n_total++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h24 ||
            ID_pc_plus4 !== 32'h24)
            $display("FAIL mask_br got req=%0b addr=%h p=%h want 1/24/24",
                     imem_bus.imem_req, imem_bus.imem_addr, ID_pc_plus4);
        else n_pass++;
    endtask

    task automatic test_branch();
`ifdef BRANCH_DELAY_SLOT_EN
        drive(1, 0, 1, 32'h200, mem_word(32'h40));
        tick();
        n_total++;
        if (ID_valid !== 1'b1 || ID_instr !== mem_word(32'h40) ||
            ID_pc_plus4 !== 32'h44)
            $display("FAIL br_slot got v=%0b i=%h p=%h want 1/%h/44",
                     ID_valid, ID_instr, ID_pc_plus4, mem_word(32'h40));
        else n_pass++;
        n_total++;
        if (imem_bus.imem_addr !== 32'h200)
            $display("FAIL br_tgt got addr=%h want 200", imem_bus.imem_addr);
        else n_pass++;
`else
        drive(0, 0, 1, 32'h103, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40 ||
                ID_valid !== 1'b0)
                $display("FAIL br_disc got req=%0b addr=%h v=%0b want 1/40/0",
                         imem_bus.imem_req, imem_bus.imem_addr, ID_valid);
            else n_pass++;
            if (k == 0) tick();
            else drive(1, 0, 0, 0, mem_word(32'h40));
        end
        tick();
        n_total++;
        if (ID_valid !== 1'b0 || imem_bus.imem_addr !== 32'h100)
            $display("FAIL br_drop got v=%0b addr=%h want 0/100",
                     ID_valid, imem_bus.imem_addr);
        else n_pass++;
        drive(1, 0, 0, 0, mem_word(32'h100));
        tick();
        n_total++;
        if (ID_valid !== 1'b1 || ID_pc_plus4 !== 32'h104)
            $display("FAIL br_resume got v=%0b p=%h want 1/104",
                     ID_valid, ID_pc_plus4);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_branch();
        drive(0, 0, 1, 32'h500, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0 ||
            ID_valid !== 1'b0 || ID_instr !== NOP || ID_pc_plus4 !== 0)
            $display("FAIL rst_mid got req=%0b addr=%h v=%0b i=%h p=%h",
                     imem_bus.imem_req, imem_bus.imem_addr, ID_valid,
                     ID_instr, ID_pc_plus4);
        else n_pass++;
        drive(1, 0, 0, 0, 32'hFACE_FACE);
        #1;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0)
            $display("FAIL rst_restart got req=%0b addr=%h want 1/0",
                     imem_bus.imem_req, imem_bus.imem_addr);
        else n_pass++;
        drive(1, 0, 0, 0, mem_word(32'h0));
        tick();
        n_total++;
        if (ID_valid !== 1'b1 || ID_pc_plus4 !== 32'h4)
            $display("FAIL rst_refetch got v=%0b p=%h want 1/4",
                     ID_valid, ID_pc_plus4);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        started, buf_v, redir_v;
        logic [31:0] m_pc, bufw, redir;
        logic [31:0] e_instr, e_pc4;
        logic        e_valid, e_req;
        logic        r, s, sel;
        logic [31:0] t, d;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        started = 0; buf_v = 0; redir_v = 0;
        m_pc = 0; bufw = 0; redir = 0;
        e_instr = NOP; e_pc4 = 0; e_valid = 0;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom % 4) != 0;
            s = ($urandom % 5) == 0;
            sel = ($urandom % 6) == 0;
            t = $urandom;
            e_req = started && !buf_v;
            d = (r && e_req) ? mem_word(m_pc) : $urandom;
            drive(r, s, sel, t, d);
            n_total++;
            if (imem_bus.imem_req !== e_req ||
                (e_req && imem_bus.imem_addr !== m_pc))
                $display("FAIL rnd_bus c=%0d got req=%0b addr=%h want %0b/%h",
                         c, imem_bus.imem_req, imem_bus.imem_addr, e_req, m_pc);
            else n_pass++;
            t = t & ~32'd3;
            if (!started) begin
                started = 1;
            end else if (s) begin
                if (r && !redir_v && !buf_v) begin
                    buf_v = 1; bufw = d;
                end
            end else if (buf_v) begin
                buf_v = 0;
`ifdef BRANCH_DELAY_SLOT_EN
                e_instr = bufw; e_pc4 = m_pc + 4; e_valid = 1;
                m_pc = sel ? t : m_pc + 4;
`else
                if (sel) begin
                    e_instr = NOP; e_valid = 0; m_pc = t;
                end else begin
                    e_instr = bufw; e_pc4 = m_pc + 4; e_valid = 1;
                    m_pc = m_pc + 4;
                end
`endif
            end else if (redir_v) begin
                e_instr = NOP; e_valid = 0;
                if (r) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    e_instr = d; e_pc4 = m_pc + 4; e_valid = 1;
`endif
                    m_pc = redir; redir_v = 0;
                end
            end else if (sel) begin
                e_instr = NOP; e_valid = 0;
                if (r) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    e_instr = d; e_pc4 = m_pc + 4; e_valid = 1;
`endif
                    m_pc = t;
                end else begin
                    redir_v = 1; redir = t;
                end
            end else if (r) begin
                e_instr = d; e_pc4 = m_pc + 4; e_valid = 1;
                m_pc = m_pc + 4;
            end else begin
                e_instr = NOP; e_valid = 0;
            end
            tick();
            n_total++;
            if (ID_valid !== e_valid || ID_instr !== e_instr ||
                (e_valid && ID_pc_plus4 !== e_pc4))
                $display("FAIL rnd_id c=%0d got v=%0b i=%h p=%h want %0b/%h/%h",
                         c, ID_valid, ID_instr, ID_pc_plus4,
                         e_valid, e_instr, e_pc4);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait(32'h0, 4);
        test_wait_states();
        test_zero_wait(32'h14, 3);
        test_stall();
        test_stall_masks_branch();
        test_zero_wait(32'h24, 7);
        test_branch();
        test_reset_mid_branch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
